// File: rtl/clkgen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clkgen_pkg
//  Description : Shared types and helpers for the clock-waveform controller.
//                Holds the controller state encoding, the waveform config
//                record {period, high} and the config legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package clkgen_pkg;

    // Default counter width; the top-level CW parameter tracks this value.
    localparam int CFG_W = 8;

    // Shortest period that still leaves room for both a high and a low phase.
    localparam logic [CFG_W-1:0] MIN_PERIOD = CFG_W'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_e;

    typedef struct packed {
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] high;
    } cfg_t;

    // A config is usable when the waveform has at least one high and one
    // low cycle per period: N >= 2 and 1 <= H <= N-1.
    function automatic logic cfg_legal(input cfg_t c);
        return (c.period >= MIN_PERIOD) && (c.high != '0) && (c.high < c.period);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clkgen_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : clkgen_cnt
//  Description : Period counter for the waveform controller. Counts
//                0..term and wraps to 0. The terminal value (N-1) is latched
//                once at config load so the wrap compare is a plain equality.
//  Ports       : i_clr       - force the count to 0 on the next edge
//                i_inc       - advance (with wrap) on the next edge
//                i_load      - latch i_term as the new terminal value
//                i_term      - terminal count N-1 of the incoming config
//                o_cnt_nxt   - count that will be current after the next edge
//                o_first_nxt - o_cnt_nxt is the first cycle of a period
//                o_last      - current count is the last cycle of the period
//  Revision    : 1.0 - initial release
// ============================================================================
module clkgen_cnt
    import clkgen_pkg::*;
#(
    parameter int CW = CFG_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc,
    input  logic          i_load,
    input  logic [CW-1:0] i_term,
    output logic [CW-1:0] o_cnt_nxt,
    output logic          o_first_nxt,
    output logic          o_last
);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_term;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_last;

    // Terminal compare uses the term latched for the period in progress; a
    // term loaded on the same edge only governs the following period.
    assign w_last = (r_cnt == r_term);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_inc) begin
            w_cnt_nxt = w_last ? '0 : r_cnt + CW'(1);
        end
    end

    assign o_cnt_nxt   = w_cnt_nxt;
    assign o_first_nxt = (w_cnt_nxt == '0);
    assign o_last      = w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_term <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (i_load) begin
                r_term <= i_term;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/clkgen_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clkgen_ctrl
//  Description : Runtime-programmable divided-clock waveform generator.
//                Period N and high time H (in clk cycles) are accepted over
//                a valid/ready handshake and only ever take effect at a period
//                boundary, so the output never glitches or truncates a pulse.
//  Ports       : clk, rst               - clock, synchronous active-high reset
//                en                     - run request (level)
//                cfg_valid/cfg_ready    - config handshake
//                cfg_period, cfg_high   - offered N and H
//                cfg_err                - pulse: offered config was illegal
//                clk_out                - generated waveform (registered)
//                tick                   - pulse on the first cycle of a period
//                active                 - waveform running
//                pending                - accepted config awaiting boundary
//  Revision    : 1.0 - initial release
// ============================================================================
module clkgen_ctrl
    import clkgen_pkg::*;
#(
    parameter int CW = CFG_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_period,
    input  logic [CW-1:0] cfg_high,
    output logic          cfg_err,
    output logic          clk_out,
    output logic          tick,
    output logic          active,
    output logic          pending
);

    state_e        r_state;
    state_e        w_state_nxt;
    cfg_t          r_act;
    cfg_t          r_shd;
    cfg_t          w_act_nxt;
    cfg_t          w_shd_nxt;
    cfg_t          w_offer;
    logic          r_loaded;
    logic          w_loaded_nxt;
    logic          r_err;
    logic          r_clk_out;
    logic          r_tick;
    logic          r_active;
    logic          r_pending;
    logic          w_ready;
    logic          w_hs;
    logic          w_legal;
    logic          w_acc;
    logic          w_clr;
    logic          w_inc;
    logic          w_load;
    logic          w_run_nxt;
    logic [CW-1:0] w_term;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_first_nxt;
    logic          w_last;

    // Ready drops during reset and while a shadow config is waiting, so at
    // most one config is ever in flight.
    assign w_ready = !rst && (r_state != S_PEND);
    assign w_offer = '{period: cfg_period, high: cfg_high};
    assign w_legal = cfg_legal(w_offer);
    assign w_hs    = cfg_valid && w_ready;
    assign w_acc   = w_hs && w_legal;
    assign w_term  = w_act_nxt.period - CW'(1);

    clkgen_cnt #(
        .CW (CW)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_clr),
        .i_inc       (w_inc),
        .i_load      (w_load),
        .i_term      (w_term),
        .o_cnt_nxt   (w_cnt_nxt),
        .o_first_nxt (w_first_nxt),
        .o_last      (w_last)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_act_nxt    = r_act;
        w_shd_nxt    = r_shd;
        w_loaded_nxt = r_loaded;
        w_clr        = 1'b0;
        w_inc        = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Counter parked at 0 so a start always begins a fresh period.
                w_clr = 1'b1;
                if (w_acc) begin
                    w_act_nxt    = w_offer;
                    w_loaded_nxt = 1'b1;
                    w_load       = 1'b1;
                end
                if (en && (r_loaded || w_acc)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_inc = 1'b1;
                if (w_last) begin
                    // Boundary cycle: a new config goes straight to the next period.
                    if (w_acc) begin
                        w_act_nxt = w_offer;
                        w_load    = 1'b1;
                    end
                    if (!en) begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_acc) begin
                    w_shd_nxt   = w_offer;
                    w_state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                w_inc = 1'b1;
                if (w_last) begin
                    w_act_nxt   = r_shd;
                    w_load      = 1'b1;
                    w_state_nxt = en ? S_RUN : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_run_nxt = (w_state_nxt != S_IDLE);

    // Outputs are registered from next-cycle values so they line up with the
    // count that becomes current on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_act     <= '0;
            r_shd     <= '0;
            r_loaded  <= 1'b0;
            r_err     <= 1'b0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            r_active  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_act     <= w_act_nxt;
            r_shd     <= w_shd_nxt;
            r_loaded  <= w_loaded_nxt;
            r_err     <= w_hs && !w_legal;
            r_clk_out <= w_run_nxt && (w_cnt_nxt < w_act_nxt.high);
            r_tick    <= w_run_nxt && w_first_nxt;
            r_active  <= w_run_nxt;
            r_pending <= (w_state_nxt == S_PEND);
        end
    end

    assign cfg_ready = w_ready;
    assign cfg_err   = r_err;
    assign clk_out   = r_clk_out;
    assign tick      = r_tick;
    assign active    = r_active;
    assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_clkgen_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clkgen_ctrl
//  Description : Self-checking bench for clkgen_ctrl. A behavioural model
//                tracks the waveform as "position within the current period"
//                plus the active and waiting configs, and predicts every
//                output cycle by cycle. Directed scenarios come first, then
//                a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clkgen_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_period = '0;
    logic [7:0] cfg_high = '0;
    logic       cfg_ready;
    logic       cfg_err;
    logic       clk_out;
    logic       tick;
    logic       active;
    logic       pending;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: what the current cycle looks like.
    bit m_run, m_pend, m_loaded, m_err;
    int m_pos, m_n, m_h, m_sn, m_sh;

    always #5 clk = ~clk;

    clkgen_ctrl #(.CW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_err    (cfg_err),
        .clk_out    (clk_out),
        .tick       (tick),
        .active     (active),
        .pending    (pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: predict from the inputs currently applied, let the
    // edge happen, compare the registered outputs.
    task automatic step();
        bit ready, hs, legal, acc;
        int on, oh;
        #1;
        ready = !rst && !m_pend;
        chk("cfg_ready", cfg_ready, ready);
        if (rst) begin
            m_run = 0; m_pend = 0; m_loaded = 0; m_err = 0;
            m_pos = 0; m_n = 0; m_h = 0; m_sn = 0; m_sh = 0;
        end else begin
            on    = int'(cfg_period);
            oh    = int'(cfg_high);
            hs    = cfg_valid && ready;
            legal = (on >= 2) && (oh >= 1) && (oh < on);
            acc   = hs && legal;
            m_err = hs && !legal;
            if (!m_run) begin
                if (acc) begin m_n = on; m_h = oh; m_loaded = 1; end
                if (en && m_loaded) begin m_run = 1; m_pos = 0; end
            end else if (m_pos == m_n - 1) begin
                if (m_pend) begin
                    m_n = m_sn; m_h = m_sh; m_pend = 0;
                end else if (acc) begin
                    m_n = on; m_h = oh;
                end
                m_pos = 0;
                if (!en) m_run = 0;
            end else begin
                m_pos = m_pos + 1;
                if (acc) begin m_sn = on; m_sh = oh; m_pend = 1; end
            end
        end
        @(posedge clk);
        #1;
        chk("clk_out", clk_out, m_run && (m_pos < m_h));
        chk("tick",    tick,    m_run && (m_pos == 0));
        chk("active",  active,  m_run);
        chk("pending", pending, m_pend);
        chk("cfg_err", cfg_err, m_err);
        @(negedge clk);
    endtask

    task automatic offer(input int n, input int h);
        cfg_valid  = 1'b1;
        cfg_period = 8'(n);
        cfg_high   = 8'(h);
        step();
        cfg_valid  = 1'b0;
    endtask

    task automatic wait_pos(input int k);
        for (int i = 0; i < 600 && !(m_run && m_pos == k); i++) step();
    endtask

    initial begin
        logic [4:0] pat;
        int pc;
        int n;

        // Reset values
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // 5/2 waveform started with config and en in the same cycle
        en = 1'b1;
        offer(5, 2);
        pat = 5'b11000;
        for (int i = 0; i < 10; i++) begin
            chk("pattern_5_2", clk_out, pat[4 - (i % 5)]);
            step();
        end

        // Illegal configs are rejected without disturbing the waveform
        offer(4, 4);
        chk("err_pulse_a", cfg_err, 1);
        offer(1, 0);
        chk("err_pulse_b", cfg_err, 1);
        step();
        chk("err_clears", cfg_err, 0);

        // Config on the boundary cycle applies directly, no pending phase
        wait_pos(4);
        offer(5, 1);
        pc = 0;
        for (int i = 0; i < 6; i++) begin
            if (pending) pc++;
            step();
        end
        chk("boundary_no_pend", pc, 0);

        // Mid-period config waits in the shadow for the boundary
        wait_pos(1);
        offer(5, 2);
        pc = 0;
        for (int i = 0; i < 6; i++) begin
            if (pending) pc++;
            step();
        end
        chk("pend_len", pc, 3);
        repeat (5) step();

        // Stop honoured at the period end, then restart from cnt 0
        wait_pos(1);
        en = 1'b0;
        for (int i = 0; i < 10 && m_run; i++) step();
        step();
        chk("stopped_clk_out", clk_out, 0);
        en = 1'b1;
        step();
        chk("restart_tick", tick, 1);
        repeat (6) step();

        // Largest period: counter must wrap at 254 without overflowing
        wait_pos(4);
        offer(255, 254);
        repeat (300) step();
        wait_pos(254);
        offer(5, 2);
        repeat (6) step();

        // Reset mid-period; without a new config en alone cannot restart
        wait_pos(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();
        chk("stay_idle", active, 0);

        // Randomized phase
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
            cfg_valid = ($urandom_range(0, 5) == 0);
            n = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 9));
            cfg_period = 8'(n);
            cfg_high   = 8'($urandom_range(0, n + 1));
            step();
        end
        cfg_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clkgen_ctrl.md
# clkgen_ctrl

Runtime-programmable clock-waveform controller for the 100 MHz clock-generation path. Produces a divided output waveform with programmable period and high time, in whole input cycles. Changes are accepted over a valid/ready handshake and applied only at a period boundary, so the output never glitches or truncates a pulse. It sequences start, stop and reconfiguration of the divider on behalf of a software or control-FSM requester.

## Interface
- CW, 8, width of the period/high-time counters (max period 2^CW−1)
- clk  in  1  input clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- en  in  1  run request; level-sensitive
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  controller can accept a configuration this cycle
- cfg_period  in  CW  period N in clk cycles
- cfg_high  in  CW  high time H in clk cycles
- cfg_err  out  1  one-cycle pulse: offered config rejected
- clk_out  out  1  generated waveform, registered
- tick  out  1  one-cycle pulse on the first cycle of every period
- active  out  1  waveform currently running
- pending  out  1  accepted config waiting for the period boundary

## Operation
- Reset: rst is synchronous, active-high; clk is the clock.
- Values after reset:
  - clk_out=0, tick=0, active=0, pending=0, cfg_err=0.
  - cfg_ready=0 while rst is high.
  - Active config cleared; loaded flag=0.
- Legal config: N≥2 and 1≤H≤N−1. Legality is checked on cfg_valid&&cfg_ready.
  - Illegal config: not applied; cfg_err pulses on the next cycle; state unchanged.
  - Legal config: handshake completes and the config is accepted.
- States: IDLE, RUN, PEND.
- IDLE:
  - cfg_ready=1. A legal config loads the active registers directly and sets loaded.
  - Go to RUN when en && loaded. A config accepted in the same cycle counts.
- RUN:
  - Counter cnt runs 0..N−1 and wraps to 0.
  - clk_out=1 in cycles with cnt<H.
  - tick=1 in cycles with cnt==0.
  - cfg_ready=1.
  - Config accepted on the boundary cycle (cnt==N−1) applies to the next period directly; state stays RUN.
  - Config accepted on any other cycle goes to the shadow register; next state PEND.
- PEND:
  - cfg_ready=0; pending=1; waveform continues with the old config.
  - At cnt==N−1, shadow→active; next state RUN.
- Stop: en low in RUN/PEND is honoured only at cnt==N−1. The current period completes, a pending config is applied, and the next state is IDLE with clk_out=0.
- en high again in IDLE restarts from cnt=0 with the stored config.
- rst mid-period: waveform aborts at the next edge; all outputs go to reset values; loaded clears.

## Timing
- Start latency:
  - en && loaded sampled at edge t.
  - From edge t+1: active=1, cnt=0, clk_out=1, tick=1.
- Outputs are registered and change only on posedge clk. Duty resolution is one input cycle; no negedge logic.
- Reconfiguration takes effect on the first cycle after the current period's last cycle. Worst-case latency is N cycles after acceptance.
- cfg_err is asserted exactly one cycle after the rejected handshake cycle.
- Arithmetic is unsigned CW-bit. cnt compare uses N−1, computed once at load.
- N=2^CW−1 is legal; the counter must not overflow.

## Structure
- Package clkgen_pkg holds:
  - state enum (IDLE, RUN, PEND)
  - MIN_PERIOD=2
  - config struct {period, high}
  - legality function
- Sub-module clkgen_cnt: wrap counter with load/clear. It outputs cnt, last (cnt==N−1) and first (cnt==0).
- The FSM, shadow register and output registers live in clkgen_ctrl.

## Test plan
- Config N=5, H=2, en=1: clk_out 1,1,0,0,0 repeating (20 MHz, 40%); tick every 5 cycles; first high one cycle after en sampled.
- Running N=5, H=1; offer N=5, H=2 at cnt=1: pending=1 for 3 cycles; the current period finishes as 1,0,0,0,0; next period starts 1,1,0,0,0 with no glitch.
- Offer N=4, H=4, then N=1, H=0: each gives cfg_err one-cycle pulse, no handshake effect; waveform unchanged.
- Running N=5, H=2; drop en at cnt=1: period completes; active=0 and clk_out=0 from the following cycle. Raise en again: restart at cnt=0.
- Config offered on the boundary cycle while running: applied to the very next period; pending never asserts.
- Assert rst at cnt=3 of a 5-cycle period: next cycle all outputs at reset values. en=1 afterwards without a new config: remains IDLE.
